// File: rtl/addsub_rr_scheduler.sv
// addsub_rr_scheduler
//   Shares one 32-bit add/sub datapath among NUM_REQ requesters. Arbitration
//   is round-robin with one operation in flight. The result is registered and
//   handed off with valid/ready backpressure.
//
// Parameters
//   NUM_REQ : number of requesters (2..8)
//   ID_W    : width of rsp_id, 2**ID_W >= NUM_REQ
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[NUM_REQ]    per-requester request
//   req_ready[NUM_REQ]    one-hot grant strobe, IDLE cycle only
//   req_a/req_b           packed operands, requester i at [32i+31:32i]
//   req_sub[NUM_REQ]      1 = A-B, 0 = A+B
//   rsp_valid/rsp_ready   result handshake
//   rsp_id                index of the requester owning the result
//   rsp_sum/rsp_cout      result and carry-out (subtract: 1 = no borrow)
//   rsp_ovf               signed overflow when ADDSUB_SCHED_OVF_EN is defined,
//                         otherwise constant 0
//
// Build option: define ADDSUB_SCHED_OVF_EN to enable overflow detection.

module adder_subtractor_operator (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] total;

  // cin doubles as the subtract select: invert B and add one.
  assign total       = {1'b0, a} + {1'b0, b ^ {32{cin}}} + {32'd0, cin};
  assign {cout, sum} = total;
endmodule

module addsub_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf
);

  localparam int unsigned NREQ = NUM_REQ;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_last;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic            op_sub;
  logic [ID_W-1:0] op_id;

  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic            sel_sub;

  logic [31:0]     add_sum;
  logic            add_cout;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int unsigned cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(rr_last) + k) % NREQ;
      if (!grant_found && (|(req_valid & (NUM_REQ'(1) << cand)))) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(cand);
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        sel_a   = req_a[32*i +: 32];
        sel_b   = req_b[32*i +: 32];
        sel_sub = |(req_sub & (NUM_REQ'(1) << i));
      end
    end
  end

  // Grant strobe is combinational and lives only for the IDLE cycle. It is
  // also forced low while reset is held, so no grant shows during reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && grant_found) begin
      req_ready = NUM_REQ'(1) << grant_id;
    end
  end

  adder_subtractor_operator u_addsub (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_last   <= ID_W'(NUM_REQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      op_sub    <= 1'b0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            op_sub  <= sel_sub;
            op_id   <= grant_id;
            rr_last <= grant_id;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= add_sum;
          rsp_cout  <= add_cout;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDSUB_SCHED_OVF_EN
  logic ovf;

  // Signed overflow: the effective operands agree in sign but the result does not.
  assign ovf = op_sub ? ((op_a[31] != op_b[31]) && (add_sum[31] != op_a[31]))
                      : ((op_a[31] == op_b[31]) && (add_sum[31] != op_a[31]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf <= 1'b0;
    end else if (state == EXEC) begin
      rsp_ovf <= ovf;
    end
  end
`else
  assign rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Self-checking bench for addsub_rr_scheduler. Directed scenarios plus a
// randomized run, all compared against a behavioural model that picks the
// round-robin winner by search and computes results with plain arithmetic.
module tb_addsub_rr_scheduler;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    req_sub;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_sum;
  logic            rsp_cout;
  logic            rsp_ovf;

  int checks   = 0;
  int failures = 0;
  int last;

  logic [31:0] va [N];
  logic [31:0] vb [N];
  logic        vs [N];

  always #5 clk = ~clk;

  addsub_rr_scheduler #(
    .NUM_REQ (N),
    .ID_W    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    va[i] = a;
    vb[i] = b;
    vs[i] = s;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_sub[i]        = s;
  endtask

  // Winner = first valid requester after the last one served, wrapping.
  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] es, output logic ec, output logic eo);
    longint sa;
    longint sb;
    longint r;
    logic [32:0] w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      es = a - b;
      ec = (a >= b);
      r  = sa - sb;
    end else begin
      w  = {1'b0, a} + {1'b0, b};
      es = w[31:0];
      ec = w[32];
      r  = sa + sb;
    end
`ifdef ADDSUB_SCHED_OVF_EN
    eo = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
    eo = 1'b0;
`endif
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, rsp_valid, 0);
    chk({tag, "_rst_sum"},   rsp_sum,   0);
    chk({tag, "_rst_id"},    rsp_id,    0);
    chk({tag, "_rst_cout"},  rsp_cout,  0);
    chk({tag, "_rst_ovf"},   rsp_ovf,   0);
    chk({tag, "_rst_ready"}, req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last  = N - 1;
  endtask

  // One full transaction from the IDLE cycle through handshake; hold = extra
  // RESP cycles with rsp_ready low.
  task automatic do_op(input string tag, input int hold);
    int          g;
    logic [31:0] es;
    logic        ec;
    logic        eo;
    logic [N-1:0] oh;
    #1;
    g = pick();
    if (g < 0) begin
      chk({tag, "_nogrant"}, req_ready, 0);
      return;
    end
    oh    = '0;
    oh[g] = 1'b1;
    model(va[g], vb[g], vs[g], es, ec, eo);
    chk({tag, "_grant"}, req_ready, oh);
    rsp_ready = (hold == 0);
    @(negedge clk);
    last = g;
    chk({tag, "_exec_ready"}, req_ready, 0);
    chk({tag, "_exec_valid"}, rsp_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_id"},    rsp_id,    g);
    chk({tag, "_sum"},   rsp_sum,   es);
    chk({tag, "_cout"},  rsp_cout,  ec);
    chk({tag, "_ovf"},   rsp_ovf,   eo);
    chk({tag, "_resp_ready"}, req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, rsp_valid, 1);
      chk({tag, "_hold_sum"},   rsp_sum,   es);
      chk({tag, "_hold_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_valid"}, rsp_valid, 0);
    chk({tag, "_done_sum"},   rsp_sum,   es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [N-1:0] oh;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'd0, 32'd0, 1'b0);

    do_reset("init");

    // Single add on requester 0.
    set_req(0, 32'd5, 32'd7, 1'b0);
    req_valid = 4'b0001;
    do_op("add0", 0);
    req_valid = '0;

    // Subtract with and without borrow on requester 1.
    set_req(1, 32'd3, 32'd5, 1'b1);
    req_valid = 4'b0010;
    do_op("sub_borrow", 0);
    set_req(1, 32'd5, 32'd3, 1'b1);
    do_op("sub_noborrow", 0);
    req_valid = '0;

    // All four requesting: 0,1,2,3,0.
    @(negedge clk);
    do_reset("rr4");
    set_req(0, 32'd100, 32'd1, 1'b0);
    set_req(1, 32'd200, 32'd2, 1'b1);
    set_req(2, 32'd300, 32'd3, 1'b0);
    set_req(3, 32'd400, 32'd4, 1'b1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) do_op("rr4", 0);
    req_valid = '0;

    // 1010 after reset: 1,3,1.
    do_reset("rr2");
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) do_op("rr2", 0);

    // Backpressure with other requesters waiting.
    req_valid = 4'b0110;
    do_op("bp", 5);
    do_op("bp_next", 0);
    req_valid = '0;

    // Reset while an operation is in EXEC.
    @(negedge clk);
    set_req(2, 32'h1234, 32'h1, 1'b0);
    req_valid = 4'b0100;
    #1;
    g     = pick();
    oh    = '0;
    oh[g] = 1'b1;
    chk("abort_grant", req_ready, oh);
    @(negedge clk);
    do_reset("abort");
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end

    // Carry out of the top bit.
    set_req(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    req_valid = 4'b0001;
    do_op("wrap", 0);

    // Overflow cases.
    set_req(0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    do_op("ovf_add", 0);
    set_req(0, 32'h8000_0000, 32'd1, 1'b1);
    do_op("ovf_sub", 0);
    set_req(0, 32'd5, 32'd3, 1'b1);
    do_op("ovf_none", 0);
    req_valid = '0;

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++) begin
        logic [31:0] ra;
        logic [31:0] rb;
        ra = $urandom;
        rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
        if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
        if ($urandom_range(0, 5) == 0) rb = 32'h7FFF_FFFF;
        set_req(i, ra, rb, 1'($urandom_range(0, 1)));
      end
      req_valid = 4'($urandom_range(0, 15));
      if (req_valid == '0) begin
        #1;
        chk("rnd_idle_ready", req_ready, 0);
        @(negedge clk);
        chk("rnd_idle_valid", rsp_valid, 0);
      end else begin
        do_op("rnd", $urandom_range(0, 2));
      end
    end
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_rr_scheduler.md
Name: addsub_rr_scheduler

Overview:
- Shares one 32-bit add/sub datapath (the `adder_subtractor_operator` instance: `sum`/`cout` from A, B, cin; cin=1 means subtract) among NUM_REQ requesters.
- Round-robin arbitration, one operation in flight, registered result with valid/ready backpressure.
- Sits between requester blocks (ALU clients, address generators) and the shared adder.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ready  output  NUM_REQ  per-requester accept strobe.
- req_a  input  NUM_REQ*32  operand A, requester i at bits [32i+31:32i].
- req_b  input  NUM_REQ*32  operand B, same packing.
- req_sub  input  NUM_REQ  1 = A-B, 0 = A+B.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_sum  output  32  result.
- rsp_cout  output  1  adder carry-out; for subtract, 1 = no borrow (A >= B unsigned).
- rsp_ovf  output  1  signed overflow (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_last=NUM_REQ-1, so requester 0 has highest priority first.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, operand regs=0.
- FSM states IDLE, EXEC, RESP.
  - IDLE: if any req_valid, grant the first set bit searching rr_last+1, rr_last+2, ... modulo NUM_REQ.
    - req_ready[g]=1 combinationally for that cycle only; all other req_ready=0.
    - On the edge: capture a, b, sub, id into operand regs; rr_last<=g; go to EXEC.
    - If no req_valid: stay in IDLE, all req_ready=0.
  - EXEC: drive the adder from the operand regs (A=op_a, B=op_b, cin=op_sub).
    - On the edge: register sum, cout, ovf and id into the rsp_* regs; go to RESP.
  - RESP: rsp_valid=1. Outputs hold stable until rsp_ready=1, then go to IDLE (rsp_valid drops next cycle).
- req_ready is 0 in EXEC and RESP. A requester must hold valid, operands and sub stable until it sees req_ready. Deasserting valid before grant is legal; the request is simply not served.
- Latency: grant edge to rsp_valid is 2 cycles. Minimum issue interval is 3 cycles.
- Arithmetic: 33-bit result {cout,sum} = A + (B ^ {32{sub}}) + sub. Wraps modulo 2^32.
- Simultaneous requests: exactly one grant per IDLE cycle. A continuously requesting client is served within NUM_REQ operations (starvation-free).
- rsp_ready high outside RESP is ignored.
- Reset mid-operation aborts the in-flight operation; no response is produced; arbitration restarts at requester 0.
- rsp_sum/rsp_cout/rsp_id keep their last values after handshake until the next EXEC.

Optional Feature:
- Macro ADDSUB_SCHED_OVF_EN.
- Defined: rsp_ovf registered in EXEC.
  - Add: ovf = (a[31]==b[31]) && (sum[31]!=a[31]).
  - Subtract: ovf = (a[31]!=b[31]) && (sum[31]!=a[31]).
- Undefined: rsp_ovf tied to 0 and no overflow logic is synthesized. The port is present in both builds.

Test Plan:
- Reset, then req_valid=0001, a=5, b=7, sub=0 → req_ready[0] pulses 1 cycle; 2 cycles later rsp_valid=1, rsp_sum=12, rsp_cout=0, rsp_id=0.
- Requester 1: a=3, b=5, sub=1 → rsp_sum=0xFFFFFFFE, rsp_cout=0. Then a=5, b=3, sub=1 → rsp_sum=2, rsp_cout=1.
- req_valid=1111 held with distinct operands → grant order 0,1,2,3,0; each response carries the matching rsp_id and sum. With 1010 held after reset → order 1,3,1.
- rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_sum stable, all req_ready=0; raising rsp_ready → IDLE next cycle, next grant follows.
- rst_n asserted during EXEC → outputs zero immediately, no rsp_valid after release; then 0xFFFFFFFF+1 → rsp_sum=0, rsp_cout=1.
- ADDSUB_SCHED_OVF_EN defined: 0x7FFFFFFF+1 → rsp_ovf=1; 0x80000000-1 → rsp_ovf=1; 5-3 → 0. Undefined: rsp_ovf=0 in all cases.
